hsv_pattern_seq: RTL
====================

Name: hsv_pattern_seq

Overview:
- Parametrised frame sequencer that generates one HSV value per LED for a multi-LED WS2812 chain.
- Replaces the single-pixel hue counter in the top level.
- On each frame tick (TE from the WS2812 driver) it streams NUM_LED {addr, H, S, V} beats over valid/ready into the hsv2rgb converter.
- Supports solid, rainbow, breathing and rainbow+breathing modes, with per-frame hue advance.

Parameters:
- NUM_LED, 16, LEDs per frame, 1..1024.
- ADDR_W, 10, pixel address width; must satisfy 2^ADDR_W >= NUM_LED.
- PIXEL_STEP, 22, hue increment between adjacent pixels, 0..359.
- FRAME_STEP, 1, base-hue increment per completed frame, 0..359.
- SAT, 200, constant saturation emitted on every beat.
- VAL_MAX, 30, value ceiling; also the value used in non-breathing modes.
- VAL_MIN, 2, value floor for breathing; must satisfy VAL_MIN <= VAL_MAX.
- VAL_STEP, 1, value change per frame in breathing modes, 1..255.

Ports:
- sys_clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- te  in  1  frame tick, 1-cycle pulse from the WS2812 driver.
- enable  in  1  allow new frames to start.
- mode  in  2  0=solid, 1=rainbow, 2=breathing, 3=rainbow+breathing.
- hsv_valid  out  1  beat valid.
- hsv_ready  in  1  downstream accept.
- hsv_addr  out  ADDR_W  pixel index.
- hsv_hue  out  9  hue, 0..359.
- hsv_sat  out  8  saturation.
- hsv_val  out  8  value.
- frame_busy  out  1  high while in SWEEP.
- frame_done  out  1  1-cycle pulse after the last beat is accepted.

Behaviour:
- Reset is synchronous: rst_n low at a sys_clk edge forces state IDLE and clears all outputs (hsv_valid, hsv_addr, hsv_hue, hsv_sat, hsv_val, frame_busy, frame_done all 0).
- Reset internal state: base_hue=0, breath_val=VAL_MIN, breath_dir=up, pixel counter=0.
- Reset mid-frame abandons the frame immediately; no frame_done is produced.
- State IDLE:
  - te=1 && enable=1 -> SWEEP.
  - On entry, latch mode into mode_q; set cur_hue=base_hue, addr=0.
  - hsv_valid rises the cycle after te (latency 1).
- State SWEEP:
  - hsv_valid=1. Outputs hold stable while hsv_valid && !hsv_ready.
  - On handshake (valid && ready): if addr==NUM_LED-1 -> DONE; else addr+1, and cur_hue advances by PIXEL_STEP if mode_q[0]=1, otherwise holds.
  - Hue add is modular: sum = cur_hue + PIXEL_STEP in 10 bits, minus 360 when sum >= 360. Result is always 0..359.
  - hsv_val = breath_val if mode_q[1]=1, else VAL_MAX. hsv_sat = SAT.
- State DONE (1 cycle):
  - hsv_valid=0, frame_done=1.
  - base_hue advances by FRAME_STEP modulo 360.
  - If mode_q[1]=1, breath_val steps toward the active limit. On reaching or crossing a limit it clamps to that limit and reverses direction: a triangle wave, never outside [VAL_MIN, VAL_MAX].
  - Return to IDLE.
- te while in SWEEP or DONE is ignored (dropped). te while enable=0 is ignored.
- Deasserting enable mid-frame completes the current frame. Changing mode mid-frame has no effect until the next frame.
- NUM_LED=1: a single beat with addr=0, then DONE.
- frame_busy = (state==SWEEP).

Optional Feature:
- Macro HSV_PATTERN_TE_DROP_CNT_EN.
- Defined: adds output te_drop_cnt [7:0], which counts te pulses ignored because state != IDLE. It saturates at 255 and is cleared by reset.
- Undefined: the port and counter are absent; drop behaviour is otherwise identical.

Decomposition:
- Package hsv_pattern_pkg holds:
  - HUE_MOD=360 and hue width 9.
  - Mode encodings MODE_SOLID/RAINBOW/BREATH/RAINBOW_BREATH.
  - State encodings IDLE/SWEEP/DONE.
- Sub-module hue_mod_add: combinational 9-bit + 9-bit modulo-360 adder, used for both the pixel step and the frame step.

Test Plan:
- Rainbow, NUM_LED=4, PIXEL_STEP=100, base 0, hsv_ready=1 -> hues 0,100,200,300; addrs 0..3; frame_done 1 cycle after the 4th beat; next frame starts at hue 1.
- Wrap: PIXEL_STEP=100, base forced to 350 (after 350 frames at FRAME_STEP=1) -> hues 350,90,190,290.
- Backpressure: hsv_ready toggled 1,0,0,1 -> the beat held for 3 cycles with identical addr/hue/val; no beat lost or duplicated.
- Breathing, VAL_MIN=2, VAL_MAX=5, VAL_STEP=2 -> per-frame val 2,4,5,3,2,4; all pixels in a frame share the same hue.
- te pulsed mid-SWEEP and with enable=0 -> no new frame; with macro defined, te_drop_cnt increments by 1 for the mid-SWEEP pulse only.
- rst_n low for 1 cycle at beat 2 of 4 -> hsv_valid=0 next cycle, no frame_done, next te restarts at addr 0, hue 0.

Source files
------------

// File: rtl/hsv_pattern_pkg.sv
// hsv_pattern_pkg: shared constants and encodings for the HSV frame sequencer.
// Hue arithmetic is modulo 360 on 9-bit values.
package hsv_pattern_pkg;

    localparam int HUE_MOD = 360;
    localparam int HUE_W   = 9;

    // Pattern modes: bit 0 selects per-pixel hue advance, bit 1 selects breathing value.
    typedef enum logic [1:0] {
        MODE_SOLID          = 2'd0,
        MODE_RAINBOW        = 2'd1,
        MODE_BREATH         = 2'd2,
        MODE_RAINBOW_BREATH = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/hue_mod_add.sv
// hue_mod_add: combinational modulo-360 adder for two hue operands.
// Both operands are expected in 0..359, so a single conditional subtract suffices.
module hue_mod_add
    import hsv_pattern_pkg::*;
(
    input  logic [HUE_W-1:0] a_i,
    input  logic [HUE_W-1:0] b_i,
    output logic [HUE_W-1:0] sum_o
);

    logic [HUE_W:0] raw;

    // Add in one extra bit, then fold back into 0..359.
    always_comb begin
        raw = {1'b0, a_i} + {1'b0, b_i};
        if (raw >= (HUE_W+1)'(HUE_MOD)) begin
            sum_o = HUE_W'(raw - (HUE_W+1)'(HUE_MOD));
        end else begin
            sum_o = raw[HUE_W-1:0];
        end
    end

endmodule

// File: rtl/hsv_pattern_seq.sv
// hsv_pattern_seq: per-frame HSV sequencer for a WS2812 chain.
// On each accepted frame tick it streams NUM_LED {addr, H, S, V} beats over
// valid/ready, then advances the base hue and (in breathing modes) the value.
// Optional: define HSV_PATTERN_TE_DROP_CNT_EN to add te_drop_cnt, a saturating
// count of frame ticks dropped because a frame was already in progress.
module hsv_pattern_seq
    import hsv_pattern_pkg::*;
#(
    parameter int NUM_LED    = 16,
    parameter int ADDR_W     = 10,
    parameter int PIXEL_STEP = 22,
    parameter int FRAME_STEP = 1,
    parameter int SAT        = 200,
    parameter int VAL_MAX    = 30,
    parameter int VAL_MIN    = 2,
    parameter int VAL_STEP   = 1
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              te,
    input  logic              enable,
    input  logic [1:0]        mode,
    output logic              hsv_valid,
    input  logic              hsv_ready,
    output logic [ADDR_W-1:0] hsv_addr,
    output logic [HUE_W-1:0]  hsv_hue,
    output logic [7:0]        hsv_sat,
    output logic [7:0]        hsv_val,
    output logic              frame_busy,
    output logic              frame_done
`ifdef HSV_PATTERN_TE_DROP_CNT_EN
    ,
    output logic [7:0]        te_drop_cnt
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_LED - 1);

    state_e             state_q;
    logic [1:0]         mode_q;
    logic [HUE_W-1:0]   base_hue_q;
    logic [7:0]         breath_val_q;
    logic               breath_up_q;
    logic               valid_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [HUE_W-1:0]   hue_q;
    logic [7:0]         sat_q;
    logic [7:0]         val_q;
    logic               busy_q;
    logic               done_q;

    logic [HUE_W-1:0]   pix_hue_d;
    logic [HUE_W-1:0]   base_hue_d;
    logic [7:0]         breath_val_d;
    logic               breath_up_d;

    hue_mod_add u_pix_add (
        .a_i   (hue_q),
        .b_i   (HUE_W'(PIXEL_STEP)),
        .sum_o (pix_hue_d)
    );

    hue_mod_add u_frame_add (
        .a_i   (base_hue_q),
        .b_i   (HUE_W'(FRAME_STEP)),
        .sum_o (base_hue_d)
    );

    // Next breathing value: step toward the active limit, clamp and reverse on reaching it.
    always_comb begin
        breath_val_d = breath_val_q;
        breath_up_d  = breath_up_q;
        if (breath_up_q) begin
            if (({1'b0, breath_val_q} + 9'(VAL_STEP)) >= 9'(VAL_MAX)) begin
                breath_val_d = 8'(VAL_MAX);
                breath_up_d  = 1'b0;
            end else begin
                breath_val_d = breath_val_q + 8'(VAL_STEP);
            end
        end else begin
            if ({1'b0, breath_val_q} <= (9'(VAL_MIN) + 9'(VAL_STEP))) begin
                breath_val_d = 8'(VAL_MIN);
                breath_up_d  = 1'b1;
            end else begin
                breath_val_d = breath_val_q - 8'(VAL_STEP);
            end
        end
    end

    // Frame FSM with registered beat outputs; ticks outside IDLE are simply not acted on.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mode_q       <= 2'd0;
            base_hue_q   <= '0;
            breath_val_q <= 8'(VAL_MIN);
            breath_up_q  <= 1'b1;
            valid_q      <= 1'b0;
            addr_q       <= '0;
            hue_q        <= '0;
            sat_q        <= 8'd0;
            val_q        <= 8'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (te && enable) begin
                        state_q <= SWEEP;
                        mode_q  <= mode;
                        addr_q  <= '0;
                        hue_q   <= base_hue_q;
                        sat_q   <= 8'(SAT);
                        val_q   <= mode[1] ? breath_val_q : 8'(VAL_MAX);
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (hsv_ready) begin
                        if (addr_q == LAST_ADDR) begin
                            state_q <= DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                            if (mode_q[0]) begin
                                hue_q <= pix_hue_d;
                            end
                        end
                    end
                end
                DONE: begin
                    done_q     <= 1'b0;
                    base_hue_q <= base_hue_d;
                    if (mode_q[1]) begin
                        breath_val_q <= breath_val_d;
                        breath_up_q  <= breath_up_d;
                    end
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef HSV_PATTERN_TE_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    // Count ticks that arrive while a frame is in progress, saturating at 255.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            drop_cnt_q <= 8'd0;
        end else if (te && (state_q != IDLE) && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign te_drop_cnt = drop_cnt_q;
`endif

    assign hsv_valid  = valid_q;
    assign hsv_addr   = addr_q;
    assign hsv_hue    = hue_q;
    assign hsv_sat    = sat_q;
    assign hsv_val    = val_q;
    assign frame_busy = busy_q;
    assign frame_done = done_q;

endmodule
